// File: rtl/sched_pkg.sv
// Shared types and constants for the four-queue round-robin scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sched_pkg;

  localparam int QID_W = 2;
  localparam int PAY_W = 2;
  localparam int NUM_Q = 4;

  // Packet as delivered by the entry block: queue id in the upper bits.
  typedef struct packed {
    logic [QID_W-1:0] qid;
    logic [PAY_W-1:0] payload;
  } pkt_t;

  // Output stage occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_e;

  // Bits needed to count 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// Circular DEPTH x PAY_W FIFO with occupancy count; a push into a full FIFO is taken when popped the same cycle.
// Latency: written entry is visible at head one cycle after the push edge.
// Backpressure: none upstream; caller sees full and decides (the top counts drops).
// Ports: clk, rst_n, flush (sync clear), push/push_data, pop, head, occ, full, empty.
module sched_fifo
  import sched_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int OCC_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [PAY_W-1:0] push_data,
  input  logic             pop,
  output logic [PAY_W-1:0] head,
  output logic [OCC_W-1:0] occ,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PAY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] cnt;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (cnt == OCC_W'(DEPTH));
  assign empty = (cnt == '0);
  assign occ   = cnt;
  assign head  = mem[rd_ptr];

  // A full FIFO that is popping this cycle frees its head slot, so the
  // incoming write lands in the slot being vacated by the read pointer.
  assign wr_en = push && (!full || pop) && !flush;
  assign rd_en = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + OCC_W'(1);
        2'b01:   cnt <= cnt - OCC_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no valid bits; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rr_queue_scheduler.sv
// Four per-queue FIFOs drained round-robin into one registered valid/ready output, with per-queue drop counters.
// Latency: packet pushed at edge N is presented after edge N+1 when the system is idle.
// Backpressure: out_ready stalls the output stage; input has none, overflowing pushes are dropped and counted.
// Ports: clk, rst_n, in_valid/in_data, flush, out_valid/out_ready/out_qid/out_data, occ, drop_cnt.
module rr_queue_scheduler
  import sched_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int CNT_W = 8,
  localparam int OCC_W = occ_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [3:0]             in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_qid,
  output logic [1:0]             out_data,
  output logic [NUM_Q*OCC_W-1:0] occ,
  output logic [NUM_Q*CNT_W-1:0] drop_cnt
);

  pkt_t             in_pkt;
  pkt_t             out_pkt;
  stage_e           stage;
  logic [QID_W-1:0] rr_ptr;

  logic [NUM_Q-1:0] q_full;
  logic [NUM_Q-1:0] q_empty;
  logic [NUM_Q-1:0] q_push;
  logic [NUM_Q-1:0] q_pop;
  logic [PAY_W-1:0] q_head [NUM_Q];

  logic [QID_W-1:0] sel;
  logic [QID_W-1:0] cand;
  logic             any;
  logic             load;

  assign in_pkt = pkt_t'(in_data);

  // Pick the first non-empty queue after rr_ptr. Scanning from the farthest
  // candidate to the nearest lets the nearest one win; offset NUM_Q wraps to
  // rr_ptr itself, which therefore has the lowest priority.
  always_comb begin
    sel  = rr_ptr;
    cand = '0;
    any  = 1'b0;
    for (int i = NUM_Q; i >= 1; i--) begin
      cand = rr_ptr + QID_W'(i);
      if (!q_empty[cand]) begin
        sel = cand;
        any = 1'b1;
      end
    end
  end

  // Arbitration only looks at occupancy registered before this edge, so a
  // packet written this cycle cannot be popped this cycle.
  assign load  = (stage == ST_EMPTY) || out_ready;
  assign q_pop = (load && any && !flush) ? (NUM_Q'(1) << sel) : '0;

  for (genvar g = 0; g < NUM_Q; g++) begin : g_q
    logic [PAY_W-1:0] head;
    logic [OCC_W-1:0] q_occ;
    logic [CNT_W-1:0] drops;
    logic             drop;

    assign q_push[g] = in_valid && (in_pkt.qid == QID_W'(g));

    sched_fifo #(
      .DEPTH (DEPTH),
      .OCC_W (OCC_W)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (q_push[g]),
      .push_data (in_pkt.payload),
      .pop       (q_pop[g]),
      .head      (head),
      .occ       (q_occ),
      .full      (q_full[g]),
      .empty     (q_empty[g])
    );

    assign q_head[g] = head;
    assign occ[g*OCC_W +: OCC_W] = q_occ;

    // Flush discards the push outright, so it is not counted as an overflow.
    assign drop = q_push[g] && q_full[g] && !q_pop[g] && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        drops <= '0;
      end else if (drop && !(&drops)) begin
        drops <= drops + CNT_W'(1);
      end
    end

    assign drop_cnt[g*CNT_W +: CNT_W] = drops;
  end

  // Output stage: EMPTY/FULL with the presented packet held until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage   <= ST_EMPTY;
      out_pkt <= '0;
      rr_ptr  <= QID_W'(NUM_Q - 1);
    end else if (flush) begin
      stage   <= ST_EMPTY;
      out_pkt <= '0;
    end else if (load) begin
      if (any) begin
        stage           <= ST_FULL;
        out_pkt.qid     <= sel;
        out_pkt.payload <= q_head[sel];
        rr_ptr          <= sel;
      end else begin
        stage <= ST_EMPTY;
      end
    end
  end

  assign out_valid = (stage == ST_FULL);
  assign out_qid   = out_pkt.qid;
  assign out_data  = out_pkt.payload;

endmodule

// File: tb/tb_rr_queue_scheduler.sv
module tb_rr_queue_scheduler;

  localparam int DEPTH = 6;
  localparam int CNT_W = 8;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [3:0]       in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_qid;
  logic [1:0]       out_data;
  logic [4*OCC_W-1:0] occ;
  logic [4*CNT_W-1:0] drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: {qid, payload} in the order the DUT must present them.
  logic [3:0] exp_q [$];
  logic [3:0] mon_e;

  rr_queue_scheduler #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_qid   (out_qid),
    .out_data  (out_data),
    .occ       (occ),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [OCC_W-1:0] occ_of(input int q);
    return occ[q*OCC_W +: OCC_W];
  endfunction

  function automatic logic [CNT_W-1:0] drop_of(input int q);
    return drop_cnt[q*CNT_W +: CNT_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int q, input int p, input bit will_emerge);
    logic [1:0] qq;
    logic [1:0] pp;
    qq = q[1:0];
    pp = p[1:0];
    in_valid = 1'b1;
    in_data  = {qq, pp};
    if (will_emerge) exp_q.push_back({qq, pp});
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      tick();
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    out_ready = 1'b0;
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_idle"}, out_valid, 0);
    check({tag, "_occ0"}, occ, 0);
  endtask

  // Every handshake pops the scoreboard and compares what was presented.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_qid", out_qid, mon_e[3:2]);
        check("out_data", out_data, mon_e[1:0]);
      end
    end
  end

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset values.
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_qid", out_qid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_occ", occ, 0);
    check("rst_drop", drop_cnt, 0);

    // Single packet to queue 1: one edge to store, one edge to present.
    out_ready = 1'b1;
    drive(1, 2, 1'b1);
    tick();
    idle();
    check("t1_not_same_edge", out_valid, 0);
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_qid", out_qid, 1);
    check("t1_data", out_data, 2);
    tick();
    check("t1_empty_after", out_valid, 0);
    check("t1_occ", occ, 0);
    out_ready = 1'b0;

    // Two packets per queue while stalled; expected order 0,1,2,3,0,1,2,3.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < 4; q++) begin
        drive(q, q + r, 1'b1);
        tick();
      end
    idle();
    tick();
    check("t2_occ0", occ_of(0), 1);
    check("t2_occ1", occ_of(1), 2);
    check("t2_occ2", occ_of(2), 2);
    check("t2_occ3", occ_of(3), 2);
    check("t2_stage_valid", out_valid, 1);
    check("t2_stage_qid", out_qid, 0);
    drain("t2");

    // Overflow queue 2: DEPTH in the FIFO, one in the stage, two dropped.
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive(2, i, i < DEPTH + 1);
      tick();
    end
    idle();
    tick();
    check("t3_occ2", occ_of(2), DEPTH);
    check("t3_valid", out_valid, 1);
    check("t3_drop2", drop_of(2), 2);
    check("t3_drop0", drop_of(0), 0);
    check("t3_drop1", drop_of(1), 0);
    check("t3_drop3", drop_of(3), 0);
    drain("t3");

    // Full queue 3 popped and pushed on the same edge: no drop.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(3, i, 1'b1);
      tick();
    end
    idle();
    check("t4_full_before", occ_of(3), DEPTH);
    drive(3, 1, 1'b1);
    out_ready = 1'b1;
    tick();
    idle();
    out_ready = 1'b0;
    check("t4_occ3", occ_of(3), DEPTH);
    check("t4_drop3", drop_of(3), 0);
    check("t4_valid", out_valid, 1);
    check("t4_qid", out_qid, 3);
    drain("t4");

    // Stalled output holds steady; then asynchronous reset mid-cycle.
    do_reset();
    drive(1, 3, 1'b1);
    tick();
    idle();
    tick();
    check("t5_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      drive((k % 2 == 0) ? 0 : 2, k, 1'b1);
      tick();
      check("t5_hold_qid", out_qid, 1);
      check("t5_hold_data", out_data, 3);
    end
    idle();
    check("t5_occ_nonzero", (occ != 0), 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_arst_valid", out_valid, 0);
    check("t5_arst_qid", out_qid, 0);
    check("t5_arst_data", out_data, 0);
    check("t5_arst_occ", occ, 0);
    check("t5_arst_drop", drop_cnt, 0);

    // Flush with 3 queued packets and drop_cnt[0]=4.
    do_reset();
    for (int i = 0; i < DEPTH + 5; i++) begin
      drive(0, i, i < DEPTH + 1);
      tick();
    end
    idle();
    check("t6_drop0_pre", drop_of(0), 4);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("t6_occ0_pre", occ_of(0), 3);
    check("t6_valid_pre", out_valid, 1);
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
    check("t6_occ", occ, 0);
    check("t6_valid", out_valid, 0);
    check("t6_drop0_kept", drop_of(0), 4);
    drive(0, 2, 1'b1);
    tick();
    idle();
    drain("t6");

    // Drop counter saturates at 2^CNT_W-1.
    do_reset();
    for (int i = 0; i < DEPTH + 1 + 260; i++) begin
      drive(1, i, i < DEPTH + 1);
      tick();
    end
    idle();
    check("t7_drop1_sat", drop_of(1), (1 << CNT_W) - 1);
    check("t7_drop0", drop_of(0), 0);
    drain("t7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
